// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg: shared state encoding and counter widths for the uio pad arbiter
package uio_arb_pkg;
  localparam int MAX_REQ = 4;
  localparam int IDX_W = $clog2(MAX_REQ);
  localparam int HOLD_W = 4;
  localparam int TURN_W = 2;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TURN = 2'd1, ST_OWN = 2'd2} state_t;
endpackage

// File: rtl/uio_arb_if.sv
// uio_arb_if: requester bundle plus the bidirectional pad signals seen by the arbiter
interface uio_arb_if #(parameter int N_REQ = 4);
  logic ena;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] dir;
  logic [8*N_REQ-1:0] wdata;
  logic [N_REQ-1:0] gnt;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] rdata;
  logic rvalid;
  modport master(output ena, req, dir, wdata, uio_in, input gnt, uio_out, uio_oe, rdata, rvalid);
  modport slave(input ena, req, dir, wdata, uio_in, output gnt, uio_out, uio_oe, rdata, rvalid);
endinterface

// File: rtl/uio_arb_rr_pick.sv
// rr_pick: round-robin priority encoder, first set bit searching upward from last+1 with wrap
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] w_c;
  assign any = |req;
  // Walk farthest-first so the nearest candidate after last is the final assignment.
  always_comb begin
    idx = '0;
    w_c = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_c = IDX_W'((int'(last) + k) % N_REQ);
      if (req[w_c]) idx = w_c;
    end
  end
endmodule

// File: rtl/uio_arb.sv
// uio_arb: round-robin owner of the shared uio pads with bounded hold time
// and high-Z turnaround between owners; registered read path back to the owner.
module uio_arb
  import uio_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input logic clk,
  input logic rst_n,
  uio_arb_if.slave bus
);
  state_t r_state, w_state_n;
  logic [IDX_W-1:0] r_owner, r_last, w_owner_n, w_last_n, w_pick_last, w_idx;
  logic r_own_dir, w_dir_n, w_any, w_rel, w_own;
  logic [TURN_W-1:0] r_turn_cnt, w_turn_n;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_n;
  logic [N_REQ-1:0] r_gnt, w_pick_req;
  logic [7:0] r_oe, r_out, r_rdata;
  logic r_rvalid;
  // While owning, the picker only sees the other requesters and starts after the owner,
  // which is exactly the post-release view needed for a same-edge handover.
  assign w_pick_req = r_state == ST_OWN ? bus.req & ~(N_REQ'(1) << r_owner) : bus.req;
  assign w_pick_last = r_state == ST_OWN ? r_owner : r_last;
  assign w_rel = r_state == ST_OWN && (!bus.req[r_owner] || r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (w_pick_req),
    .last(w_pick_last),
    .any (w_any),
    .idx (w_idx)
  );
  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_last_n = r_last;
    w_dir_n = r_own_dir;
    w_turn_n = r_turn_cnt;
    w_hold_n = r_hold_cnt;
    if (!bus.ena) begin
      w_state_n = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      w_state_n = w_any ? ST_TURN : ST_IDLE;
      w_owner_n = w_any ? w_idx : r_owner;
      w_turn_n = '0;
    end else if (r_state == ST_TURN) begin
      w_state_n = r_turn_cnt == TURN_W'(TURN_CYC - 1) ? ST_OWN : ST_TURN;
      w_turn_n = r_turn_cnt + 1'b1;
      w_dir_n = bus.dir[r_owner];
      w_hold_n = '0;
    end else if (w_rel) begin
      w_last_n = r_owner;
      w_state_n = w_any ? ST_TURN : ST_IDLE;
      w_owner_n = w_any ? w_idx : r_owner;
      w_turn_n = '0;
    end else begin
      w_hold_n = r_hold_cnt + 1'b1;
    end
  end
  assign w_own = w_state_n == ST_OWN;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_last <= IDX_W'(N_REQ - 1);
      r_own_dir <= 1'b0;
      r_turn_cnt <= '0;
      r_hold_cnt <= '0;
      r_gnt <= '0;
      r_oe <= '0;
      r_out <= '0;
      r_rdata <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_last <= w_last_n;
      r_own_dir <= w_dir_n;
      r_turn_cnt <= w_turn_n;
      r_hold_cnt <= w_hold_n;
      r_gnt <= w_own ? N_REQ'(1) << w_owner_n : '0;
      r_oe <= {8{w_own && w_dir_n}};
      r_out <= w_own && w_dir_n ? bus.wdata[{w_owner_n, 3'b000} +: 8] : 8'h00;
      r_rdata <= bus.uio_in;
      r_rvalid <= bus.ena && r_state == ST_OWN && !r_own_dir;
    end
  end
  assign bus.gnt = r_gnt;
  assign bus.uio_oe = r_oe;
  assign bus.uio_out = r_out;
  assign bus.rdata = r_rdata;
  assign bus.rvalid = r_rvalid;
endmodule

// File: doc/uio_arb.md
# uio_arb

Arbiter and turnaround controller sharing the Tiny Tapeout bidirectional `uio` pins between up to four internal requesters inside `tt_um_johndmcmaster_hddemo`. It grants the bus round-robin and enforces a bounded hold time. It drives `uio_out`/`uio_oe` for the owner and inserts high-Z turnaround cycles between owners so two drivers never fight on the pads. Read data from `uio_in` is registered and returned to the current owner.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..4).
- `MAX_HOLD`, 8: maximum consecutive OWN cycles per grant (1..15).
- `TURN_CYC`, 1: high-Z cycles before every grant (1..3).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable; low forces IDLE.
- `req`  in  N_REQ  per-requester bus request, level.
- `dir`  in  N_REQ  per-requester direction: 1 = drive pads, 0 = read pads.
- `wdata`  in  8*N_REQ  write byte per requester; requester i uses bits [8i+7:8i].
- `gnt`  out  N_REQ  one-hot grant, registered.
- `uio_in`  in  8  pad input.
- `uio_out`  out  8  pad output, registered.
- `uio_oe`  out  8  pad output enable, registered, all-ones or all-zeros.
- `rdata`  out  8  registered `uio_in` sample.
- `rvalid`  out  1  `rdata` is valid for the current owner.

## Operation
- States: IDLE, TURN, OWN. Registers: `owner`, `last`, `own_dir`, `turn_cnt`, `hold_cnt`.
- Reset: state IDLE, `gnt`=0, `uio_oe`=0, `uio_out`=0, `rdata`=0, `rvalid`=0, `last`=N_REQ-1, so requester 0 wins first.
- IDLE: `uio_oe`=0. If `ena` and any `req` is set, the winner is the first set bit searching upward from `last`+1 mod N_REQ. Latch `owner`, clear `turn_cnt`, and go to TURN.
- TURN: `gnt`=0, `uio_oe`=0. After TURN_CYC cycles in TURN, go to OWN. On entry to OWN:
  - set `gnt[owner]`;
  - latch `own_dir`=`dir[owner]`;
  - clear `hold_cnt`.
- OWN:
  - `uio_oe` = {8{own_dir}}.
  - `uio_out` = `wdata[owner]` while `own_dir`, else 0.
  - `hold_cnt` increments each cycle.
  - Release when `req[owner]` is low or `hold_cnt` reaches MAX_HOLD-1. On release: `last`=`owner` and `gnt` clears.
  - If any other `req` is pending, go directly to TURN with the new round-robin winner; otherwise go to IDLE.
  - The released requester is eligible again only after all other pending requesters have been served.
- Changing `dir` mid-grant has no effect; `own_dir` holds until release.
- Read path: each cycle, `rdata` <= `uio_in` and `rvalid` <= (state==OWN && !own_dir).
- `ena` low in any state: next state IDLE; `gnt`, `uio_oe`, `uio_out`, `rvalid` go to 0. `last` is kept.
- `req` bits with index ≥ N_REQ do not exist; the width follows N_REQ.

## Timing
- Request latency: `req[i]` high at edge k in IDLE gives TURN after k, then `gnt[i]`/`uio_oe` high after edge k+TURN_CYC. With default parameters that is 2 cycles.
- Release latency: `req[owner]` low at edge k clears `gnt` and `uio_oe` after edge k, in the same edge as the TURN/IDLE transition.
- Forced release: at most MAX_HOLD consecutive cycles with `gnt[i]` high.
- Turnaround:
  - Between any two grants, `uio_oe`=0 for at least TURN_CYC cycles, including when the same requester is re-granted.
  - `uio_oe` never toggles 0→1 in the same cycle as an owner change.
- Read latency: `rdata` reflects `uio_in` sampled one edge earlier. `rvalid` is aligned with `rdata`.
- Simultaneous release and new requests resolve in the same edge using the updated `last`.
- Asynchronous reset mid-OWN drops `uio_oe` immediately, without waiting for a clock edge.

## Structure
- Package `uio_arb_pkg`:
  - state localparams `ST_IDLE`, `ST_TURN`, `ST_OWN` (2-bit);
  - `MAX_REQ`=4;
  - counter widths (4-bit hold, 2-bit turn).
- Sub-module `rr_pick`: combinational round-robin priority encoder with inputs `req` and `last` and outputs `any` and `idx`. It is instantiated once and shared by the IDLE and release paths.

## Test plan
- Reset and first grant: release reset with `req`=4'b0101 → `gnt`=4'b0001 two cycles later, then `gnt`=4'b0100 after the turnaround.
- Write path: requester 2 with `dir[2]`=1 and `wdata[23:16]`=8'hA5 → `uio_out`=8'hA5, `uio_oe`=8'hFF while `gnt[2]`. `uio_oe`=0 for exactly one cycle before and after the grant.
- Hold limit: `req`=4'b1111 held constant → each grant lasts exactly 8 cycles. Grant order is 0,1,2,3,0. There is one high-Z cycle between grants.
- Read path: requester 1 with `dir[1]`=0 and `uio_in` ramping 0x10,0x11,… → `rdata` lags by one cycle with `rvalid`=1. `uio_oe` stays 0.
- Enable and reset mid-operation: drop `ena` during OWN → next cycle `gnt`=0, `uio_oe`=0. Assert `rst_n`=0 mid-OWN without a clock edge → `uio_oe`=0 immediately, and `last` resets so requester 0 wins first afterwards.
